// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Front end of the fetch stage. Issues sequential single-word fetches on the
// SRAM-like instruction port (one transaction in flight at most) and queues
// the returned {pc, instruction} pairs for decode. A redirect flushes the
// queue, restarts fetch at redirect_pc, and marks any fetch still in flight
// so that its returning word is thrown away.
//
// Ports
//   clock, reset_                 clock (rising edge), async active-low reset
//   redirect_valid/redirect_pc    one-cycle flush + new fetch PC
//   instruction_ram_*             SRAM-like request/response channel
//                                 (read-only: write/size/wdata/strobe tied)
//   decode_valid/pc/instruction   queue head; pc/instruction read 0 when empty
//   decode_allowin                decode consumes the head when valid
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clock,
   input  logic        reset_,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instruction_ram_request,
   output logic        instruction_ram_write,
   output logic [1:0]  instruction_ram_size,
   output logic [31:0] instruction_ram_address,
   output logic [31:0] instruction_ram_write_data,
   output logic [3:0]  instruction_ram_write_strobe,
   input  logic [31:0] instruction_ram_read_data,
   input  logic        instruction_ram_address_ready,
   input  logic        instruction_ram_data_ready,
   output logic        decode_valid,
   output logic [31:0] decode_pc,
   output logic [31:0] decode_instruction,
   input  logic        decode_allowin
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_REQUEST   = 2'd1;
   localparam logic [1:0] ST_WAIT_DATA = 2'd2;

   logic [1:0]       state;
   logic [31:0]      fetch_pc;   // next PC to be requested
   logic [31:0]      req_pc;     // PC of the current/last issued fetch
   logic             discard;    // in-flight fetch belongs to a flushed stream

   logic [31:0]      fifo_pc  [DEPTH];
   logic [31:0]      fifo_ins [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic accept;
   logic data_done;
   logic push;
   logic pop;
   logic space;

   assign accept    = (state == ST_REQUEST) && instruction_ram_address_ready;
   assign data_done = (state == ST_WAIT_DATA) && instruction_ram_data_ready;
   assign push      = data_done && !discard && !redirect_valid;
   assign pop       = decode_valid && decode_allowin;
   // Only IDLE launches a fetch and nothing is in flight there, so a free
   // slot in the registered count is enough to guarantee room for the word.
   assign space     = count < CNT_W'(DEPTH);

   // Fetch control
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         discard  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (space) begin
                  state  <= ST_REQUEST;
                  req_pc <= redirect_valid ? redirect_pc : fetch_pc;
               end
            end
            ST_REQUEST: begin
               // req_pc is frozen here: a redirect never alters a pending request
               if (accept) state <= ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
               if (instruction_ram_data_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // A discarded fetch must not advance the PC; fetch_pc already
         // holds the redirect target in that case.
         if (redirect_valid)
            fetch_pc <= redirect_pc;
         else if (accept && !discard)
            fetch_pc <= fetch_pc + 32'd4;

         // A word returning in the redirect cycle is simply dropped, so the
         // flag is only needed when the fetch is still outstanding.
         if (redirect_valid &&
             ((state == ST_REQUEST) ||
              ((state == ST_WAIT_DATA) && !instruction_ram_data_ready)))
            discard <= 1'b1;
         else if (data_done)
            discard <= 1'b0;
      end
   end

   // Queue control
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage (data only, no reset needed)
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_pc[wr_ptr]  <= req_pc;
         fifo_ins[wr_ptr] <= instruction_ram_read_data;
      end
   end

   assign decode_valid       = (count != '0);
   assign decode_pc          = decode_valid ? fifo_pc[rd_ptr]  : 32'd0;
   assign decode_instruction = decode_valid ? fifo_ins[rd_ptr] : 32'd0;

   assign instruction_ram_request      = (state == ST_REQUEST);
   assign instruction_ram_address      = req_pc;
   assign instruction_ram_write        = 1'b0;
   assign instruction_ram_size         = 2'b10;
   assign instruction_ram_write_data   = 32'd0;
   assign instruction_ram_write_strobe = 4'd0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;

   logic        clock = 1'b0;
   logic        reset_ = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        instruction_ram_request;
   logic        instruction_ram_write;
   logic [1:0]  instruction_ram_size;
   logic [31:0] instruction_ram_address;
   logic [31:0] instruction_ram_write_data;
   logic [3:0]  instruction_ram_write_strobe;
   logic [31:0] instruction_ram_read_data = 32'd0;
   logic        instruction_ram_address_ready = 1'b0;
   logic        instruction_ram_data_ready = 1'b0;
   logic        decode_valid;
   logic [31:0] decode_pc;
   logic [31:0] decode_instruction;
   logic        decode_allowin = 1'b0;

   instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock                         (clock),
      .reset_                        (reset_),
      .redirect_valid                (redirect_valid),
      .redirect_pc                   (redirect_pc),
      .instruction_ram_request       (instruction_ram_request),
      .instruction_ram_write         (instruction_ram_write),
      .instruction_ram_size          (instruction_ram_size),
      .instruction_ram_address       (instruction_ram_address),
      .instruction_ram_write_data    (instruction_ram_write_data),
      .instruction_ram_write_strobe  (instruction_ram_write_strobe),
      .instruction_ram_read_data     (instruction_ram_read_data),
      .instruction_ram_address_ready (instruction_ram_address_ready),
      .instruction_ram_data_ready    (instruction_ram_data_ready),
      .decode_valid                  (decode_valid),
      .decode_pc                     (decode_pc),
      .decode_instruction            (decode_instruction),
      .decode_allowin                (decode_allowin)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 50)
            $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: inputs applied after a falling edge, outputs observed on the next falling edge.
   task automatic tick(input logic ar, input logic dr, input logic [31:0] rd,
                       input logic allow, input logic redir, input logic [31:0] rpc);
      instruction_ram_address_ready = ar;
      instruction_ram_data_ready    = dr;
      instruction_ram_read_data     = rd;
      decode_allowin                = allow;
      redirect_valid                = redir;
      redirect_pc                   = rpc;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset_ = 1'b0;
      instruction_ram_address_ready = 1'b0;
      instruction_ram_data_ready    = 1'b0;
      decode_allowin                = 1'b0;
      redirect_valid                = 1'b0;
      repeat (3) @(negedge clock);
      reset_ = 1'b1;
   endtask

   task automatic wait_req(input string name, input logic allow);
      for (int i = 0; i < 20 && !instruction_ram_request; i++)
         tick(1'b0, 1'b0, 32'd0, allow, 1'b0, 32'd0);
      chk(name, {31'd0, instruction_ram_request}, 32'd1);
   endtask

   // Complete the currently requested fetch: accept now, data next cycle.
   task automatic fetch(input logic [31:0] word, input logic allow);
      tick(1'b1, 1'b0, 32'd0, allow, 1'b0, 32'd0);
      tick(1'b0, 1'b1, word, allow, 1'b0, 32'd0);
   endtask

   // Auto-responding memory used by the stall sequence.
   logic        sl_busy;
   logic [31:0] sl_addr;
   logic [31:0] first_resume;
   int          n_acc;

   task automatic auto_tick(input logic allow);
      logic ar, dr;
      logic [31:0] a_now;
      ar    = instruction_ram_request;
      dr    = sl_busy;
      a_now = instruction_ram_address;
      tick(ar, dr, sl_addr ^ 32'h5a5a5a5a, allow, 1'b0, 32'd0);
      if (dr) sl_busy = 1'b0;
      if (ar) begin
         sl_busy = 1'b1;
         sl_addr = a_now;
         n_acc++;
         if (n_acc == DEPTH + 1) first_resume = a_now;
      end
   endtask

   typedef struct {
      logic        ar;
      logic        dr;
      logic [31:0] rd;
      logic        allow;
      logic        req;
      logic        chk_addr;
      logic [31:0] addr;
      logic        dv;
      logic [31:0] pc;
      logic [31:0] ins;
   } vec_t;

   vec_t tbl [9];

   // Reference model state for the randomized phase.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];
   ent_t        e;
   bit          m_out, m_out_disc, m_pend_disc, prev_held;
   logic [31:0] m_out_pc, exp_pc, prev_addr;
   logic        r_ar, r_dr, r_allow, r_redir, r_req;
   logic [31:0] r_rd, r_rpc, r_addr;
   int          pre_size, r_acc;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      //               ar   dr   rd            allow req  chka addr          dv   pc            ins
      tbl[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hbfc00000, 1'b0, 32'h0,        32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hbfc00000, 1'b0, 32'h0,        32'h0};
      tbl[2] = '{1'b0, 1'b1, 32'h24020001, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
      tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hbfc00000, 32'h24020001};
      tbl[4] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00000, 32'h24020001};
      tbl[5] = '{1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
      tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hbfc00004, 32'h11111111};
      tbl[7] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hbfc00008, 1'b0, 32'h0,        32'h0};
      tbl[8] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hbfc00008, 1'b0, 32'h0,        32'h0};

      // Reset release and first fetches
      do_reset();
      chk("tied_size", {30'd0, instruction_ram_size}, 32'd2);
      chk("tied_write", {31'd0, instruction_ram_write}, 32'd0);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("tbl%0d_req", i), {31'd0, instruction_ram_request}, {31'd0, tbl[i].req});
         if (tbl[i].chk_addr)
            chk($sformatf("tbl%0d_addr", i), instruction_ram_address, tbl[i].addr);
         chk($sformatf("tbl%0d_dv", i), {31'd0, decode_valid}, {31'd0, tbl[i].dv});
         chk($sformatf("tbl%0d_pc", i), decode_pc, tbl[i].pc);
         chk($sformatf("tbl%0d_ins", i), decode_instruction, tbl[i].ins);
         tick(tbl[i].ar, tbl[i].dr, tbl[i].rd, tbl[i].allow, 1'b0, 32'd0);
      end

      // Decode stalled: queue fills to DEPTH, then drains in order
      do_reset();
      sl_busy = 1'b0; sl_addr = 32'd0; n_acc = 0; first_resume = 32'd0;
      for (int c = 0; c < 20; c++) auto_tick(1'b0);
      chk("stall_fetches", n_acc, DEPTH);
      chk("stall_req", {31'd0, instruction_ram_request}, 32'd0);
      chk("stall_dv", {31'd0, decode_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("drain%0d_dv", i), {31'd0, decode_valid}, 32'd1);
         chk($sformatf("drain%0d_pc", i), decode_pc, RESET_PC + 32'(4 * i));
         chk($sformatf("drain%0d_ins", i), decode_instruction, (RESET_PC + 32'(4 * i)) ^ 32'h5a5a5a5a);
         auto_tick(1'b1);
      end
      chk("resume_addr", first_resume, 32'hbfc00010);

      // Redirect while waiting for data
      do_reset();
      wait_req("wd_req0", 1'b0);
      fetch(32'h00000001, 1'b0);
      chk("wd_dv_before", {31'd0, decode_valid}, 32'd1);
      wait_req("wd_req1", 1'b0);
      tick(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80001000);
      chk("wd_flush_dv", {31'd0, decode_valid}, 32'd0);
      tick(1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b0, 32'd0);
      chk("wd_dropped_dv", {31'd0, decode_valid}, 32'd0);
      wait_req("wd_req2", 1'b0);
      chk("wd_new_addr", instruction_ram_address, 32'h80001000);
      fetch(32'h3c1c8000, 1'b0);
      chk("wd_new_dv", {31'd0, decode_valid}, 32'd1);
      chk("wd_new_pc", decode_pc, 32'h80001000);
      chk("wd_new_ins", decode_instruction, 32'h3c1c8000);

      // Redirect coincident with address_ready
      do_reset();
      wait_req("ar_req0", 1'b1);
      fetch(32'h1, 1'b1);
      wait_req("ar_req1", 1'b1);
      fetch(32'h2, 1'b1);
      wait_req("ar_req2", 1'b1);
      chk("ar_addr2", instruction_ram_address, 32'hbfc00008);
      tick(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h80002000);
      tick(1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'd0);
      chk("ar_dropped_dv", {31'd0, decode_valid}, 32'd0);
      wait_req("ar_req3", 1'b1);
      chk("ar_new_addr", instruction_ram_address, 32'h80002000);

      // Redirect while a request is held unaccepted
      do_reset();
      wait_req("hold_req", 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0, 32'd0, 1'b0, (i == 1), 32'h80003000);
         chk($sformatf("hold%0d_req", i), {31'd0, instruction_ram_request}, 32'd1);
         chk($sformatf("hold%0d_addr", i), instruction_ram_address, 32'hbfc00000);
      end
      fetch(32'h44444444, 1'b0);
      chk("hold_dropped_dv", {31'd0, decode_valid}, 32'd0);
      wait_req("hold_req2", 1'b0);
      chk("hold_new_addr", instruction_ram_address, 32'h80003000);
      fetch(32'h55555555, 1'b0);
      chk("hold_new_pc", decode_pc, 32'h80003000);

      // Reset asserted mid-transaction
      do_reset();
      wait_req("rst_req0", 1'b0);
      fetch(32'h66666666, 1'b0);
      wait_req("rst_req1", 1'b0);
      tick(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #2 reset_ = 1'b0;
      #1;
      chk("rst_req", {31'd0, instruction_ram_request}, 32'd0);
      chk("rst_dv", {31'd0, decode_valid}, 32'd0);
      chk("rst_pc", decode_pc, 32'd0);
      chk("rst_ins", decode_instruction, 32'd0);
      chk("rst_addr", instruction_ram_address, RESET_PC);
      instruction_ram_address_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset_ = 1'b1;
      tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      chk("rst_restart_req", {31'd0, instruction_ram_request}, 32'd1);
      chk("rst_restart_addr", instruction_ram_address, RESET_PC);

      // Randomized traffic against a queue-level reference model
      do_reset();
      q.delete();
      m_out = 0; m_out_disc = 0; m_pend_disc = 0; prev_held = 0;
      m_out_pc = 32'd0; exp_pc = RESET_PC; prev_addr = 32'd0; r_acc = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         r_req  = instruction_ram_request;
         r_addr = instruction_ram_address;
         if (q.size() != 0) begin
            chk("rnd_dv", {31'd0, decode_valid}, 32'd1);
            chk("rnd_pc", decode_pc, q[0].pc);
            chk("rnd_ins", decode_instruction, q[0].ins);
         end else begin
            chk("rnd_dv", {31'd0, decode_valid}, 32'd0);
            chk("rnd_empty_pc", decode_pc, 32'd0);
         end
         if (prev_held) begin
            chk("rnd_hold_req", {31'd0, r_req}, 32'd1);
            chk("rnd_hold_addr", r_addr, prev_addr);
         end else if (r_req) begin
            chk("rnd_new_addr", r_addr, exp_pc);
            chk("rnd_space", {31'd0, (q.size() < DEPTH) && !m_out}, 32'd1);
         end

         r_ar    = r_req && ($urandom_range(2) != 0);
         r_dr    = m_out && ($urandom_range(1) != 0);
         r_rd    = $urandom;
         r_allow = ((cyc / 200) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
         r_redir = ($urandom_range(24) == 0);
         r_rpc   = $urandom;
         tick(r_ar, r_dr, r_rd, r_allow, r_redir, r_rpc);

         pre_size = q.size();
         if (r_redir) begin
            q.delete();
            exp_pc = r_rpc;
            if (r_dr) m_out = 0;
            else if (m_out) m_out_disc = 1;
            if (r_req) begin
               if (r_ar) begin
                  m_out = 1; m_out_pc = r_addr; m_out_disc = 1; m_pend_disc = 0; r_acc++;
               end else m_pend_disc = 1;
            end
         end else begin
            if (pre_size != 0 && r_allow) e = q.pop_front();
            if (r_dr) begin
               if (!m_out_disc) q.push_back('{m_out_pc, r_rd});
               m_out = 0;
            end
            if (r_req && r_ar) begin
               m_out = 1; m_out_pc = r_addr; m_out_disc = m_pend_disc;
               if (!m_pend_disc) exp_pc = exp_pc + 32'd4;
               m_pend_disc = 0;
               r_acc++;
            end
         end
         prev_held = r_req && !r_ar;
         prev_addr = r_addr;
      end
      chk("rnd_progress", {31'd0, r_acc > 200}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
